// File: rtl/stack_program_loader.sv
// stack_program_loader
//   Receives a framed byte stream that carries a stack-machine program and
//   writes it into instruction memory. A frame is a header byte N, then N
//   (opcode, value) byte pairs, then one checksum byte. The checksum is the
//   mod-256 sum of the header and every opcode and value byte. A frame with a
//   correct checksum raises run. A malformed frame raises error. Either flag
//   holds until the next start.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle pulse, begins or restarts a load (wins over in_valid)
//   in_valid  byte stream valid
//   in_data   byte stream data
//   in_ready  loader accepts in_data this cycle
//   wr_en     instruction memory write strobe, one cycle per instruction
//   wr_addr   instruction memory write address
//   wr_data   instruction word {opcode[3:0], value[7:0]}
//   run       program verified
//   busy      frame in progress
//   error     sticky frame error
//
// state | meaning
// IDLE  | waiting for start after reset
// HDR   | expecting header byte N
// OPC   | expecting opcode byte of the current word
// VAL   | expecting value byte of the current word
// CHK   | expecting checksum byte
// DONE  | frame verified, run held high
// ERR   | frame rejected, error held high

module stack_program_loader #(
  parameter int MAX_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [11:0] wr_data,
  output logic        run,
  output logic        busy,
  output logic        error
);

  localparam int         CW    = $clog2(MAX_WORDS + 1);
  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] OPC  = 3'd2;
  localparam logic [2:0] VAL  = 3'd3;
  localparam logic [2:0] CHK  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    addr;
  logic [7:0]    sum;
  logic [3:0]    opc;
  logic          accept;
  logic          hdr_ok;
  logic          opc_ok;
  logic          last_word;

  assign busy      = (state == HDR) || (state == OPC) || (state == VAL) || (state == CHK);
  // start blocks the handshake so the byte presented with it is not consumed
  assign in_ready  = busy && !start;
  assign accept    = in_valid && in_ready;
  assign hdr_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= MAX_N);
  assign opc_ok    = (in_data <= 8'h07);
  // cnt counts the words still owed; it reaches 1 on the last value byte
  assign last_word = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      sum     <= '0;
      opc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      run     <= 1'b0;
      error   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        state <= HDR;
        run   <= 1'b0;
        error <= 1'b0;
        cnt   <= '0;
        addr  <= '0;
        sum   <= '0;
      end else if (accept) begin
        case (state)
          HDR: begin
            if (hdr_ok) begin
              cnt   <= CW'(in_data);
              sum   <= sum + in_data;
              state <= OPC;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          OPC: begin
            if (opc_ok) begin
              opc   <= in_data[3:0];
              sum   <= sum + in_data;
              state <= VAL;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          VAL: begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= {opc, in_data};
            addr    <= addr + 5'd1;
            cnt     <= cnt - CW'(1);
            sum     <= sum + in_data;
            state   <= last_word ? CHK : OPC;
          end
          CHK: begin
            if (in_data == sum) begin
              state <= DONE;
              run   <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
